// File: rtl/ma_stage_pkg.sv
// ma_stage_pkg: shared pipeline constants for the memory-access stage.
//   - bus widths (EX->MA, MA->WB, MA->ID forwarding)
//   - ld_op encodings
//   - bit positions of every field in the EX->MA and MA->WB buses
package ma_stage_pkg;

  localparam int unsigned EX_MA_BUS_WIDTH = 74;
  localparam int unsigned MA_WB_BUS_WIDTH = 70;
  localparam int unsigned MA_FWD_WIDTH    = 38;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ld_op_e;

  // EX->MA bus fields
  localparam int unsigned EX_RES_FROM_MEM = 73;
  localparam int unsigned EX_LD_OP_HI     = 72;
  localparam int unsigned EX_LD_OP_LO     = 70;
  localparam int unsigned EX_GR_WE        = 69;
  localparam int unsigned EX_DEST_HI      = 68;
  localparam int unsigned EX_DEST_LO      = 64;
  localparam int unsigned EX_ALU_HI       = 63;
  localparam int unsigned EX_ALU_LO       = 32;
  localparam int unsigned EX_PC_HI        = 31;
  localparam int unsigned EX_PC_LO        = 0;

  // MA->WB bus fields
  localparam int unsigned WB_GR_WE     = 69;
  localparam int unsigned WB_DEST_HI   = 68;
  localparam int unsigned WB_DEST_LO   = 64;
  localparam int unsigned WB_RESULT_HI = 63;
  localparam int unsigned WB_RESULT_LO = 32;
  localparam int unsigned WB_PC_HI     = 31;
  localparam int unsigned WB_PC_LO     = 0;

endpackage

// File: rtl/ma_stage_if.sv
// ma_stage_if: handshake and data buses around the MA stage.
//   master : the surrounding pipeline (EX/WB/data SRAM side)
//   slave  : the MA stage itself
// Optional feature macro: MA_FWD_EN adds ma_to_id_fwd {we, dest, data}.
interface ma_stage_if import ma_stage_pkg::*; #(
  parameter int unsigned EX_MA_BUS_W = EX_MA_BUS_WIDTH,
  parameter int unsigned MA_WB_BUS_W = MA_WB_BUS_WIDTH
);
  logic                   ex_validout;
  logic                   wb_allowin;
  logic                   ma_allowin;
  logic                   ma_validout;
  logic [EX_MA_BUS_W-1:0] ex_to_ma_bus;
  logic [31:0]            data_sram_rdata;
  logic [MA_WB_BUS_W-1:0] ma_to_wb_bus;
  logic [4:0]             ma_to_id_dest;
`ifdef MA_FWD_EN
  logic [MA_FWD_WIDTH-1:0] ma_to_id_fwd;

  modport master (
    output ex_validout, wb_allowin, ex_to_ma_bus, data_sram_rdata,
    input  ma_allowin, ma_validout, ma_to_wb_bus, ma_to_id_dest, ma_to_id_fwd
  );
  modport slave (
    input  ex_validout, wb_allowin, ex_to_ma_bus, data_sram_rdata,
    output ma_allowin, ma_validout, ma_to_wb_bus, ma_to_id_dest, ma_to_id_fwd
  );
`else
  modport master (
    output ex_validout, wb_allowin, ex_to_ma_bus, data_sram_rdata,
    input  ma_allowin, ma_validout, ma_to_wb_bus, ma_to_id_dest
  );
  modport slave (
    input  ex_validout, wb_allowin, ex_to_ma_bus, data_sram_rdata,
    output ma_allowin, ma_validout, ma_to_wb_bus, ma_to_id_dest
  );
`endif
endinterface

// File: rtl/ma_stage_load_align.sv
// ma_load_align: combinational load-data extraction.
//   raw    : 32-bit word read from data SRAM
//   offset : byte offset (alu_result[1:0])
//   ld_op  : load type (ld_op_e); unknown codes behave as lw
//   data   : extended load result
module ma_load_align import ma_stage_pkg::*; (
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_op,
  output logic [31:0] data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (offset)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = offset[1] ? raw[31:16] : raw[15:0];

    case (ld_op)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'h0, half_sel};
      default: data = raw;
    endcase
  end
endmodule

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   ma_if  : slave side of ma_stage_if (EX handshake/bus in, WB handshake/bus
//            out, data SRAM read data in, ID hazard dest out)
// Optional feature macro: MA_FWD_EN drives ma_if.ma_to_id_fwd.
// SRAM read data is only valid in the first cycle after acceptance, so it is
// captured into a hold register if WB stalls during that cycle.
module ma_stage import ma_stage_pkg::*; #(
  parameter int unsigned EX_MA_BUS_W = EX_MA_BUS_WIDTH,
  parameter int unsigned MA_WB_BUS_W = MA_WB_BUS_WIDTH
) (
  input logic        clk,
  input logic        rst,
  ma_stage_if.slave  ma_if
);
  logic                   valid_q, valid_d;
  logic                   first_q, first_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [31:0]            hold_q, hold_d;
  logic [EX_MA_BUS_W-1:0] bus_q, bus_d;

  logic        allowin, accept;
  logic        res_from_mem, gr_we;
  logic [2:0]  ld_op;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc, raw, ld_data, final_result;

  always_comb begin
    allowin    = ~valid_q | ma_if.wb_allowin;
    accept     = ma_if.ex_validout & allowin;
    valid_d    = allowin ? ma_if.ex_validout : valid_q;
    bus_d      = accept ? ma_if.ex_to_ma_bus : bus_q;
    first_d    = accept;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (accept) begin
      hold_vld_d = 1'b0;
    end else if (first_q & valid_q & ~ma_if.wb_allowin) begin
      hold_d     = ma_if.data_sram_rdata;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      bus_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      first_q    <= first_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      bus_q      <= bus_d;
    end
  end

  always_comb begin
    res_from_mem = bus_q[EX_RES_FROM_MEM];
    ld_op        = bus_q[EX_LD_OP_HI:EX_LD_OP_LO];
    gr_we        = bus_q[EX_GR_WE];
    dest         = bus_q[EX_DEST_HI:EX_DEST_LO];
    alu_result   = bus_q[EX_ALU_HI:EX_ALU_LO];
    pc           = bus_q[EX_PC_HI:EX_PC_LO];
    raw          = hold_vld_q ? hold_q : ma_if.data_sram_rdata;
  end

  ma_load_align u_load_align (
    .raw    (raw),
    .offset (alu_result[1:0]),
    .ld_op  (ld_op),
    .data   (ld_data)
  );

  always_comb begin
    final_result        = res_from_mem ? ld_data : alu_result;
    ma_if.ma_allowin    = allowin;
    ma_if.ma_validout   = valid_q;
    ma_if.ma_to_wb_bus  = '0;
    ma_if.ma_to_wb_bus[WB_GR_WE]                  = gr_we;
    ma_if.ma_to_wb_bus[WB_DEST_HI:WB_DEST_LO]     = dest;
    ma_if.ma_to_wb_bus[WB_RESULT_HI:WB_RESULT_LO] = final_result;
    ma_if.ma_to_wb_bus[WB_PC_HI:WB_PC_LO]         = pc;
    ma_if.ma_to_id_dest = dest & {5{valid_q}};
`ifdef MA_FWD_EN
    // Loads are excluded: their data is not known early enough to forward.
    ma_if.ma_to_id_fwd  = {gr_we & valid_q & ~res_from_mem, dest, alu_result};
`endif
  end
endmodule

// File: tb/tb_ma_stage.sv
module tb_ma_stage;
  import ma_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ma_stage_if #(.EX_MA_BUS_W(74), .MA_WB_BUS_W(70)) ma_if ();

  ma_stage #(.EX_MA_BUS_W(74), .MA_WB_BUS_W(70)) dut (
    .clk   (clk),
    .rst   (rst),
    .ma_if (ma_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  logic [69:0] exp_q[$];
  logic [37:0] fwd_q[$];
  logic        acc_pending = 1'b0;
  logic [73:0] pending_bus = '0;

  task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * off[1])) & 32'hFFFF;
    case (op)
      3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [73:0] mk(input logic res, input logic [2:0] op, input logic we,
                                     input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {res, op, we, dst, alu, pc};
  endfunction

  // One cycle of stimulus; rd_first is the SRAM word for a cycle that follows
  // an acceptance, rd_other is driven in any other cycle.
  task automatic step(input logic ev, input logic [73:0] b, input logic wb,
                      input logic [31:0] rd_first, input logic [31:0] rd_other);
    logic [31:0] alu, fin;
    @(posedge clk);
    #1;
    if (acc_pending) begin
      ma_if.data_sram_rdata = rd_first;
      alu = pending_bus[63:32];
      fin = pending_bus[73] ? ref_load(rd_first, alu[1:0], pending_bus[72:70]) : alu;
      exp_q.push_back({pending_bus[69], pending_bus[68:64], fin, pending_bus[31:0]});
      fwd_q.push_back({pending_bus[69] & ~pending_bus[73], pending_bus[68:64], alu});
    end else begin
      ma_if.data_sram_rdata = rd_other;
    end
    ma_if.ex_validout  = ev;
    ma_if.ex_to_ma_bus = b;
    ma_if.wb_allowin   = wb;
    acc_pending = ev && (exp_q.size() == 0 || wb);
    pending_bus = b;
  endtask

  // Monitor: one-deep pipeline, so the DUT holds exactly the front entry.
  always @(negedge clk) begin
    logic        exp_valid;
    logic [69:0] front;
    logic [37:0] ffront;
    exp_valid = (exp_q.size() != 0);
    check("validout", {69'b0, ma_if.ma_validout}, {69'b0, exp_valid});
    check("allowin", {69'b0, ma_if.ma_allowin}, {69'b0, !exp_valid || ma_if.wb_allowin});
    if (exp_valid) begin
      front  = exp_q[0];
      ffront = fwd_q[0];
      check("wb_bus", ma_if.ma_to_wb_bus, front);
      check("id_dest", {65'b0, ma_if.ma_to_id_dest}, {65'b0, front[68:64]});
`ifdef MA_FWD_EN
      check("id_fwd", {32'b0, ma_if.ma_to_id_fwd}, {32'b0, ffront});
`endif
      if (ma_if.wb_allowin) begin
        void'(exp_q.pop_front());
        void'(fwd_q.pop_front());
        hs_count++;
      end
    end else begin
      check("id_dest_empty", {65'b0, ma_if.ma_to_id_dest}, '0);
`ifdef MA_FWD_EN
      check("id_fwd_empty", {32'b0, ma_if.ma_to_id_fwd}, '0);
`endif
    end
  end

  initial begin
    int h0;
    ma_if.ex_validout     = 1'b0;
    ma_if.wb_allowin      = 1'b0;
    ma_if.ex_to_ma_bus    = '0;
    ma_if.data_sram_rdata = '0;
    #1;
    check("rst_validout", {69'b0, ma_if.ma_validout}, '0);
    check("rst_allowin", {69'b0, ma_if.ma_allowin}, 70'd1);
    check("rst_wb_bus", ma_if.ma_to_wb_bus, '0);
    check("rst_id_dest", {65'b0, ma_if.ma_to_id_dest}, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    // ALU pass-through
    step(1'b1, mk(1'b0, LD_W, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000), 1'b1, '0, '0);
    // lb, lbu at offset 3 then lh at offset 2
    step(1'b1, mk(1'b1, LD_B,  1'b1, 5'd7, 32'h0000_0103, 32'h1004), 1'b1, $urandom, $urandom);
    step(1'b1, mk(1'b1, LD_BU, 1'b1, 5'd8, 32'h0000_0203, 32'h1008), 1'b1, 32'h80FF_7F01, $urandom);
    step(1'b1, mk(1'b1, LD_H,  1'b1, 5'd9, 32'h0000_0302, 32'h100C), 1'b1, 32'h80FF_7F01, $urandom);
    step(1'b0, '0, 1'b1, 32'h8001_ABCD, $urandom);
    step(1'b0, '0, 1'b1, $urandom, $urandom);

    // lw under a 3-cycle WB stall; SRAM data changes after the first cycle
    step(1'b1, mk(1'b1, LD_W, 1'b1, 5'd10, 32'h0000_2000, 32'h1010), 1'b1, $urandom, $urandom);
    step(1'b0, '0, 1'b0, 32'hCAFE_F00D, 32'h0);
    step(1'b1, mk(1'b0, LD_W, 1'b1, 5'd11, 32'h1, 32'h1014), 1'b0, 32'h0, 32'hDEAD_BEEF);
    step(1'b1, mk(1'b0, LD_W, 1'b1, 5'd11, 32'h1, 32'h1014), 1'b0, 32'h0, 32'hDEAD_BEEF);
    step(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step(1'b0, '0, 1'b1, $urandom, $urandom);

    // back-to-back flow of 4 instructions
    h0 = hs_count;
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(1'b0, LD_W, 1'b1, 5'(12 + i), 32'h100 * i, 32'h2000 + 4 * i), 1'b1,
           $urandom, $urandom);
    step(1'b0, '0, 1'b1, $urandom, $urandom);
    @(negedge clk);
    #1;
    check("b2b_handshakes", 70'(hs_count - h0), 70'd4);

    // reset asserted in the middle of a stall
    step(1'b1, mk(1'b1, LD_H, 1'b1, 5'd20, 32'h3002, 32'h3000), 1'b1, $urandom, $urandom);
    step(1'b0, '0, 1'b0, $urandom, $urandom);
    step(1'b0, '0, 1'b0, $urandom, $urandom);
    #1;
    rst = 1'b0;
    exp_q.delete();
    fwd_q.delete();
    acc_pending = 1'b0;
    ma_if.ex_validout = 1'b0;
    #1;
    check("midrst_validout", {69'b0, ma_if.ma_validout}, '0);
    check("midrst_id_dest", {65'b0, ma_if.ma_to_id_dest}, '0);
    check("midrst_allowin", {69'b0, ma_if.ma_allowin}, 70'd1);
    check("midrst_wb_bus", ma_if.ma_to_wb_bus, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, $urandom, $urandom);

    // randomized traffic with random stalls and load types
    for (int i = 0; i < 400; i++) begin
      logic [73:0] b;
      b = {$urandom, $urandom, $urandom};
      step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6), $urandom, $urandom);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, $urandom, $urandom);
    @(negedge clk);
    #1;
    check("drained", 70'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 SHALL have parameter EX_MA_BUS_W, default 74, giving the EX-to-MA bus width.
REQ-002 SHALL have parameter MA_WB_BUS_W, default 70, giving the MA-to-WB bus width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ex_validout, input, 1 bit: EX holds a valid instruction for MA.
REQ-006 SHALL have port wb_allowin, input, 1 bit: WB can accept this cycle.
REQ-007 SHALL have port ma_allowin, output, 1 bit: MA can accept from EX.
REQ-008 SHALL have port ma_validout, output, 1 bit: MA presents a valid instruction to WB.
REQ-009 SHALL have port ex_to_ma_bus, input, 74 bits, packed as {res_from_mem[73], ld_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-010 SHALL have port data_sram_rdata, input, 32 bits: load data, valid only in the first cycle after EX-to-MA acceptance.
REQ-011 SHALL have port ma_to_wb_bus, output, 70 bits, packed as {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-012 SHALL have port ma_to_id_dest, output, 5 bits: dest gated by valid, for hazard detection.
REQ-013 SHALL have port ma_to_id_fwd, output, 38 bits, packed as {we, dest, data}; present only under MA_FWD_EN.

Function
REQ-014 SHALL register ex_to_ma_bus when ex_validout & ma_allowin; the bus register is otherwise unchanged.
REQ-015 SHALL set valid <= ex_validout whenever ma_allowin is high.
REQ-016 SHALL drive ready_go = 1 and ma_allowin = ~valid | wb_allowin.
REQ-017 SHALL drive ma_validout = valid.
REQ-018 SHALL maintain a first flag: set on acceptance, cleared on the next edge.
REQ-019 SHALL maintain a hold register plus hold_vld flag:
- On a first-flag cycle with valid & ~wb_allowin, capture data_sram_rdata and set hold_vld.
- Clear hold_vld on any new acceptance.
REQ-020 SHALL select raw load data as follows: hold register when hold_vld, else data_sram_rdata.
REQ-021 SHALL extract load data using byte offset alu_result[1:0], with ld_op encoded as:
- 000 lw: full word.
- 001 lb: sign-extended byte at offset.
- 010 lbu: zero-extended byte at offset.
- 011 lh: sign-extended half at offset[1].
- 100 lhu: zero-extended half at offset[1].
- 101-111: treated as lw.
REQ-022 SHALL set final_result to the extracted load data if res_from_mem, else alu_result.
REQ-023 SHALL have zero latency from MA register to WB bus; one instruction passes through per cycle when not stalled.
REQ-024 SHALL, when ex_validout and wb_allowin are both high with valid high, retire the current instruction to WB and accept the new one on the same edge.
REQ-025 SHALL drive ma_to_id_dest = dest & {5{valid}}, giving 0 when empty.
REQ-026 SHALL keep the bus and hold register stable under a sustained ~wb_allowin stall of any length.

Reset
REQ-027 SHALL, while rst = 0, clear valid, first, hold_vld, the bus register and the hold register to 0, independent of clk.
REQ-028 SHALL, under reset, drive ma_validout = 0, ma_allowin = 1, ma_to_wb_bus = 0, ma_to_id_dest = 0 and ma_to_id_fwd = 0.
REQ-029 SHALL discard any in-flight instruction when reset is asserted mid-stall; no WB handshake occurs afterwards.

Configuration
REQ-030 SHALL use macro MA_FWD_EN. When defined: ma_to_id_fwd = {gr_we & valid & ~res_from_mem, dest, alu_result}, with loads excluded. When undefined: the port is absent and only ma_to_id_dest is provided.

Structure
REQ-031 SHALL place the following in the shared pipeline package:
- Bus-width constants (74, 70, 38).
- ld_op encodings.
- Bus field bit positions.
REQ-032 SHALL implement load extraction (REQ-021) as sub-module ma_load_align, purely combinational, with inputs raw, offset, ld_op and output data.

Verification
REQ-033 SHALL verify ALU pass-through: alu_result = 0x12345678, res_from_mem = 0, gr_we = 1, dest = 5 -> next cycle ma_to_wb_bus = {1, 5, 0x12345678, pc}.
REQ-034 SHALL verify lb sign extension: rdata = 0x80FF7F01, offset 3, lb -> final_result = 0xFFFFFF80; with lbu -> 0x00000080.
REQ-035 SHALL verify lh sign extension: rdata = 0x8001ABCD, offset 2, lh -> final_result = 0xFFFF8001.
REQ-036 SHALL verify a load under stall: lw accepted, wb_allowin = 0 for 3 cycles, rdata changes to 0xDEADBEEF after the first cycle -> final_result holds the first-cycle word throughout and at the release handshake.
REQ-037 SHALL verify back-to-back flow: ex_validout = 1 and wb_allowin = 1 continuously for 4 instructions -> 4 consecutive ma_validout cycles and no bubbles.
REQ-038 SHALL verify reset during a stall: rst pulled low mid-stall -> ma_validout = 0 and ma_to_id_dest = 0 immediately, and ma_allowin = 1.
